debounce_ctrl: RTL and testbench



---
 rtl/debounce_pkg.sv | 27 ++
 rtl/debounce_ctrl_sync.sv | 23 ++
 rtl/debounce_ctrl.sv | 152 +++++++++++++++
 tb/tb_debounce_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce controller slice.
// No logic; constants only.
// No flow control.
package debounce_pkg;

  // Confirm FSM states: two settled levels and two "checking" states
  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } state_t;

  // Ceiling log2, usable in parameter expressions; clog2(1) = 0
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_ctrl_sync.sv
// Flop-chain synchroniser for a raw asynchronous single-bit input.
// Latency: STAGES clocks from D to Q.
// No backpressure; samples every clock.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] ff;

  // Shift the raw input through the chain; reset clears every stage
  always_ff @(posedge CLK) begin
    if (RST) ff <= '0;
    else     ff <= {ff[STAGES-2:0], D};
  end

  assign Q = ff[STAGES-1];

endmodule

// File: rtl/debounce_ctrl.sv
// Glitch filter: synchronise D, sample on a prescaled tick, accept a new level after STABLE_N agreeing samples.
// Latency: SYNC_STAGES+STABLE_N-1 clocks from capture to Q with DIV=1; add up to DIV-1 per sample otherwise.
// No backpressure; RISE/FALL/GLITCH are single-cycle pulses registered alongside Q.
module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV         = 1,
  parameter int STABLE_N    = 3,
  parameter int GCNT_W      = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              D,
  input  logic              CLR_CNT,
  output logic              Q,
  output logic              RISE,
  output logic              FALL,
  output logic              GLITCH,
  output logic [GCNT_W-1:0] GLITCH_CNT
);

  localparam int CW = clog2(STABLE_N + 1);
  localparam int TW = (DIV > 1) ? clog2(DIV) : 1;
  // cnt value whose next agreeing sample completes the confirm run
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);
  localparam logic [TW-1:0] TICK_AT  = TW'(DIV - 1);

  logic          s;
  logic          tick;
  logic [TW-1:0] tcnt;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          q_nxt, rise_nxt, fall_nxt, glitch_nxt;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (D),
    .Q   (s)
  );

  assign tick = (tcnt == TICK_AT);

  // Prescaler: count 0..DIV-1 and wrap on the tick cycle
  always_ff @(posedge CLK) begin
    if (RST)       tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // Confirm FSM next state: only tick cycles may move it
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    q_nxt      = Q;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    glitch_nxt = 1'b0;
    if (tick) begin
      case (state)
        S_LO: begin
          if (s) begin
            if (STABLE_N == 1) begin
              state_nxt = S_HI;
              q_nxt     = 1'b1;
              rise_nxt  = 1'b1;
            end else begin
              state_nxt = S_CHK_HI;
              cnt_nxt   = CW'(1);
            end
          end
        end
        S_CHK_HI: begin
          if (s) begin
            if (cnt == CNT_LAST) begin
              state_nxt = S_HI;
              q_nxt     = 1'b1;
              rise_nxt  = 1'b1;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else begin
            state_nxt  = S_LO;
            glitch_nxt = 1'b1;
            cnt_nxt    = '0;
          end
        end
        S_HI: begin
          if (!s) begin
            if (STABLE_N == 1) begin
              state_nxt = S_LO;
              q_nxt     = 1'b0;
              fall_nxt  = 1'b1;
            end else begin
              state_nxt = S_CHK_LO;
              cnt_nxt   = CW'(1);
            end
          end
        end
        S_CHK_LO: begin
          if (!s) begin
            if (cnt == CNT_LAST) begin
              state_nxt = S_LO;
              q_nxt     = 1'b0;
              fall_nxt  = 1'b1;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else begin
            state_nxt  = S_HI;
            glitch_nxt = 1'b1;
            cnt_nxt    = '0;
          end
        end
        default: begin
          state_nxt = S_LO;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state, filtered level and event pulses; reset drops any pending change silently
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_LO;
      cnt    <= '0;
      Q      <= 1'b0;
      RISE   <= 1'b0;
      FALL   <= 1'b0;
      GLITCH <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      Q      <= q_nxt;
      RISE   <= rise_nxt;
      FALL   <= fall_nxt;
      GLITCH <= glitch_nxt;
    end
  end

  // Saturating glitch counter; a clear beats a same-cycle increment
  always_ff @(posedge CLK) begin
    if (RST)                                  GLITCH_CNT <= '0;
    else if (CLR_CNT)                         GLITCH_CNT <= '0;
    else if (glitch_nxt && !(&GLITCH_CNT))    GLITCH_CNT <= GLITCH_CNT + 1'b1;
  end

endmodule

// File: tb/tb_debounce_ctrl.sv
module tb_debounce_ctrl;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  // Three instances: defaults, narrow counter, slow tick
  logic rst[3];
  logic d[3];
  logic clr[3];
  logic q[3];
  logic rise[3];
  logic fall[3];
  logic glitch[3];
  logic [7:0] gc0;
  logic [1:0] gc1;
  logic [7:0] gc2;

  debounce_ctrl u0 (
    .CLK(clk), .RST(rst[0]), .D(d[0]), .CLR_CNT(clr[0]),
    .Q(q[0]), .RISE(rise[0]), .FALL(fall[0]), .GLITCH(glitch[0]), .GLITCH_CNT(gc0)
  );

  debounce_ctrl #(.SYNC_STAGES(2), .DIV(1), .STABLE_N(3), .GCNT_W(2)) u1 (
    .CLK(clk), .RST(rst[1]), .D(d[1]), .CLR_CNT(clr[1]),
    .Q(q[1]), .RISE(rise[1]), .FALL(fall[1]), .GLITCH(glitch[1]), .GLITCH_CNT(gc1)
  );

  debounce_ctrl #(.SYNC_STAGES(2), .DIV(4), .STABLE_N(2), .GCNT_W(8)) u2 (
    .CLK(clk), .RST(rst[2]), .D(d[2]), .CLR_CNT(clr[2]),
    .Q(q[2]), .RISE(rise[2]), .FALL(fall[2]), .GLITCH(glitch[2]), .GLITCH_CNT(gc2)
  );

  int div_p[3]  = '{1, 1, 4};
  int sn_p[3]   = '{3, 3, 2};
  int gmax_p[3] = '{255, 3, 255};

  // Behavioural model: D seen two edges ago is the sample; a run of samples
  // disagreeing with Q flips Q once it reaches STABLE_N, and a run cut short
  // by an agreeing sample is a glitch.
  bit m_d1[3], m_d2[3];
  int m_ph[3], m_run[3], m_g[3];
  bit m_q[3], m_rise[3], m_fall[3], m_gl[3];

  task automatic model_step(input int k);
    bit smp;
    bit tk;
    if (rst[k]) begin
      m_d1[k] = 0; m_d2[k] = 0; m_ph[k] = 0; m_run[k] = 0; m_g[k] = 0;
      m_q[k] = 0; m_rise[k] = 0; m_fall[k] = 0; m_gl[k] = 0;
    end else begin
      smp = m_d2[k];
      m_d2[k] = m_d1[k];
      m_d1[k] = d[k];
      m_rise[k] = 0; m_fall[k] = 0; m_gl[k] = 0;
      tk = (m_ph[k] == div_p[k] - 1);
      m_ph[k] = tk ? 0 : m_ph[k] + 1;
      if (tk) begin
        if (smp != m_q[k]) begin
          m_run[k]++;
          if (m_run[k] == sn_p[k]) begin
            m_q[k] = smp;
            m_run[k] = 0;
            if (smp) m_rise[k] = 1; else m_fall[k] = 1;
          end
        end else if (m_run[k] > 0) begin
          m_gl[k] = 1;
          m_run[k] = 0;
        end
      end
      if (clr[k]) m_g[k] = 0;
      else if (m_gl[k] && m_g[k] < gmax_p[k]) m_g[k]++;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  int checks = 0;
  int errors = 0;
  bit armed = 0;
  int nrise[3] = '{0, 0, 0};
  int nfall[3] = '{0, 0, 0};
  int ngl[3]   = '{0, 0, 0};

  function automatic int dut_g(input int k);
    case (k)
      0:       return int'(gc0);
      1:       return int'(gc1);
      default: return int'(gc2);
    endcase
  endfunction

  // Per-cycle comparison against the model, plus observed pulse tallies
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== m_q[k] || rise[k] !== m_rise[k] || fall[k] !== m_fall[k] ||
            glitch[k] !== m_gl[k] || dut_g(k) != m_g[k]) begin
          errors++;
          $display("FAIL model_u%0d t=%0t: got q=%b rise=%b fall=%b glitch=%b gcnt=%0d, want q=%b rise=%b fall=%b glitch=%b gcnt=%0d",
                   k, $time, q[k], rise[k], fall[k], glitch[k], dut_g(k),
                   m_q[k], m_rise[k], m_fall[k], m_gl[k], m_g[k]);
        end
        if (rise[k] === 1'b1)   nrise[k]++;
        if (fall[k] === 1'b1)   nfall[k]++;
        if (glitch[k] === 1'b1) ngl[k]++;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int br, bf, bg;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; d[k] = 1'b0; clr[k] = 1'b0;
    end
    // Reset held two cycles with D=1 on u0
    d[0] = 1'b1;
    cyc(1);
    armed = 1'b1;
    cyc(1);
    chk("reset_q", int'(q[0]), 0);
    chk("reset_gcnt", int'(gc0), 0);
    chk("reset_pulses", int'(rise[0]) + int'(fall[0]) + int'(glitch[0]), 0);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    br = nrise[0];
    cyc(4);
    chk("post_reset_q_early", int'(q[0]), 0);
    cyc(1);
    chk("post_reset_q_rise", int'(q[0]), 1);
    chk("post_reset_rise_pulse", int'(rise[0]), 1);
    cyc(5);
    chk("post_reset_rise_count", nrise[0] - br, 1);

    // Clean falling then rising step
    bf = nfall[0];
    d[0] = 1'b0;
    cyc(4);
    chk("fall_q_early", int'(q[0]), 1);
    cyc(1);
    chk("fall_q", int'(q[0]), 0);
    chk("fall_pulse", int'(fall[0]), 1);
    cyc(5);
    chk("fall_count", nfall[0] - bf, 1);
    br = nrise[0];
    d[0] = 1'b1;
    cyc(4);
    chk("rise_q_early", int'(q[0]), 0);
    cyc(1);
    chk("rise_q", int'(q[0]), 1);
    cyc(5);
    chk("rise_count", nrise[0] - br, 1);
    d[0] = 1'b0;
    cyc(10);
    chk("settle_low", int'(q[0]), 0);

    // Three one-cycle glitches
    bg = ngl[0];
    for (int i = 0; i < 3; i++) begin
      d[0] = 1'b1;
      cyc(1);
      d[0] = 1'b0;
      cyc(8);
      chk("glitch_cnt_step", int'(gc0), i + 1);
    end
    chk("glitch_pulses", ngl[0] - bg, 3);
    chk("glitch_q_low", int'(q[0]), 0);

    // Sub-period burst: only the samples landing on a high window count
    bg = ngl[0];
    br = nrise[0];
    #5;
    for (int i = 0; i < 5; i++) begin
      d[0] = 1'b1; #22;
      d[0] = 1'b0; #2;
      d[0] = 1'b1; #2;
      d[0] = 1'b0; #74;
    end
    @(negedge clk);
    cyc(6);
    chk("burst_glitches", ngl[0] - bg, 3);
    chk("burst_gcnt", int'(gc0), 6);
    chk("burst_no_rise", nrise[0] - br, 0);
    chk("burst_q_low", int'(q[0]), 0);

    // Saturation on the 2-bit counter, then clear racing a glitch
    bg = ngl[1];
    for (int i = 0; i < 5; i++) begin
      d[1] = 1'b1;
      cyc(1);
      d[1] = 1'b0;
      cyc(6);
    end
    chk("sat_gcnt", int'(gc1), 3);
    chk("sat_pulses", ngl[1] - bg, 5);
    d[1] = 1'b1;
    cyc(1);
    d[1] = 1'b0;
    cyc(2);
    clr[1] = 1'b1;
    cyc(1);
    chk("clr_race_glitch", int'(glitch[1]), 1);
    chk("clr_race_gcnt", int'(gc1), 0);
    clr[1] = 1'b0;
    cyc(4);
    chk("clr_hold_gcnt", int'(gc1), 0);

    // Slow tick: fresh reset fixes the tick phase
    rst[2] = 1'b1;
    cyc(2);
    rst[2] = 1'b0;
    br = nrise[2];
    bg = ngl[2];
    cyc(2);
    d[2] = 1'b1;
    cyc(7);
    d[2] = 1'b0;
    cyc(10);
    chk("div_short_no_rise", nrise[2] - br, 0);
    chk("div_short_glitch", ngl[2] - bg, 1);
    chk("div_short_gcnt", int'(gc2), 1);
    chk("div_short_q", int'(q[2]), 0);
    d[2] = 1'b1;
    cyc(8);
    chk("div_long_q_early", int'(q[2]), 0);
    cyc(1);
    chk("div_long_q", int'(q[2]), 1);
    chk("div_long_rise", int'(rise[2]), 1);
    cyc(3);
    d[2] = 1'b0;
    bf = nfall[2];
    cyc(15);
    chk("div_fall_q", int'(q[2]), 0);
    chk("div_fall_count", nfall[2] - bf, 1);

    // Reset while a rising change is pending
    d[2] = 1'b1;
    cyc(6);
    rst[2] = 1'b1;
    d[2] = 1'b0;
    cyc(2);
    rst[2] = 1'b0;
    bg = ngl[2];
    br = nrise[2];
    cyc(12);
    chk("rst_pending_no_glitch", ngl[2] - bg, 0);
    chk("rst_pending_no_rise", nrise[2] - br, 0);
    chk("rst_pending_gcnt", int'(gc2), 0);
    chk("rst_pending_q", int'(q[2]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
